// File: rtl/mem_stream_reader_if.sv
// AXI-Stream style beat bundle carrying read data from the reader to the input buffer.
interface mem_stream_reader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mem_stream_reader.sv
// Command-driven word reader: issues in-order memory reads and streams the returned data
// out as one burst, credit-limited against its own FIFO and throttled by buff_prog_full.
module mem_stream_reader #(
  parameter int ADDR_W          = 32,
  parameter int BUFF_WORD       = 32,
  parameter int LEN_W           = 16,
  parameter int RD_LATENCY      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [BUFF_WORD-1:0] mem_rd_data,
  input  logic                 buff_prog_full,
  mem_stream_reader_if.master  m_axis,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]       remain_q, remain_d;
  logic [CNT_W-1:0]       credits_q, credits_d;
  logic [RD_LATENCY-1:0]  vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0]  last_pipe_q, last_pipe_d;
  logic [BUFF_WORD-1:0]   fifo_data_q [MAX_OUTSTANDING];
  logic [BUFF_WORD-1:0]   fifo_data_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic issue;
  logic push;
  logic pop;
  logic drain_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read may only go out while a FIFO slot is reserved for its return.
  assign issue = !rst && (state_q == RUN) && (remain_q != '0) && !buff_prog_full &&
                 (credits_q < CNT_W'(MAX_OUTSTANDING));
  assign push = vld_pipe_q[RD_LATENCY-1];
  assign pop  = (count_q != '0) && m_axis.tready;
  assign drain_done = (state_q == DRAIN) && (vld_pipe_q == '0) && (count_q == '0);

  assign cmd_ready     = (state_q == IDLE) && !rst;
  assign busy          = (state_q != IDLE);
  assign done          = drain_done && !rst;
  assign mem_rd_en     = issue;
  assign mem_rd_addr   = addr_q;
  assign m_axis.tvalid = (count_q != '0);
  assign m_axis.tdata  = fifo_data_q[rd_ptr_q];
  assign m_axis.tlast  = fifo_last_q[rd_ptr_q] && (count_q != '0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          state_d  = (cmd_len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Return tagging, FIFO bookkeeping and credit accounting.
  always_comb begin
    vld_pipe_d     = '0;
    last_pipe_d    = '0;
    vld_pipe_d[0]  = issue;
    last_pipe_d[0] = issue && (remain_q == LEN_W'(1));
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end

    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_rd_data;
      fifo_last_d[wr_ptr_q] = last_pipe_q[RD_LATENCY-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q + CNT_W'(1);
      2'b01:   credits_d = credits_q - CNT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      credits_q   <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      credits_q   <= credits_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench: commands push expected addresses/beats; a negedge monitor checks the DUT.
module tb_mem_stream_reader;
  localparam int ADDR_W = 32;
  localparam int BUFF_WORD = 32;
  localparam int LEN_W = 16;
  localparam int RDL = 2;
  localparam int MAXO = 4;

  logic              mem_clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              buff_prog_full = 1'b0;
  logic              cmd_ready, mem_rd_en, busy, done;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [BUFF_WORD-1:0] mem_rd_data;

  mem_stream_reader_if #(.DATA_W(BUFF_WORD)) axis ();

  mem_stream_reader #(
    .ADDR_W(ADDR_W), .BUFF_WORD(BUFF_WORD), .LEN_W(LEN_W),
    .RD_LATENCY(RDL), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .mem_clk(mem_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .buff_prog_full(buff_prog_full), .m_axis(axis), .busy(busy), .done(done)
  );

  always #5 mem_clk = ~mem_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  // Memory model: returns the read address as data, RDL cycles after the strobe.
  logic [RDL:1]      pv = '0;
  logic [ADDR_W-1:0] pa [RDL:1];
  always @(posedge mem_clk) begin
    pv[1] <= mem_rd_en;
    pa[1] <= mem_rd_addr;
    for (int i = 2; i <= RDL; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rd_data = pv[RDL] ? pa[RDL] : 32'hDEAD_BEEF;

  int tready_mode = 0;
  int pf_mode = 0;
  bit pf_force = 1'b0;
  int phase = 0;
  always @(posedge mem_clk) begin
    #1;
    phase++;
    case (tready_mode)
      1:       axis.tready = ((phase % 3) == 0);
      2:       axis.tready = ($urandom_range(0, 1) == 1);
      default: axis.tready = 1'b1;
    endcase
    buff_prog_full = pf_force || ((pf_mode == 1) && ($urandom_range(0, 3) == 0));
  end

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [BUFF_WORD:0] exp_beat_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  int cmd_gen = 0, seen_gen = 0;
  int rd_cnt, beat_cnt, last_cnt, done_cnt, outstanding, max_out;
  int first_rd, first_tv, last_beat_cyc, done_cyc;
  bit prev_stall;
  logic [BUFF_WORD:0] prev_beat;

  always @(negedge mem_clk) begin
    if (cmd_gen != seen_gen) begin
      seen_gen = cmd_gen;
      rd_cnt = 0; beat_cnt = 0; last_cnt = 0; done_cnt = 0;
      outstanding = 0; max_out = 0;
      first_rd = -1; first_tv = -1; last_beat_cyc = -1; done_cyc = -1;
      prev_stall = 1'b0;
    end
    if (!rst) begin
      if (buff_prog_full) chk("rd_en_under_prog_full", 64'(mem_rd_en), 64'd0);
      if (mem_rd_en) begin
        rd_cnt++;
        outstanding++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
        else chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (axis.tvalid && first_tv < 0) first_tv = cyc;
      if (prev_stall)
        chk("stall_hold", 64'({axis.tvalid, axis.tlast, axis.tdata}), 64'({1'b1, prev_beat}));
      if (axis.tvalid && axis.tready) begin
        beat_cnt++;
        outstanding--;
        last_beat_cyc = cyc;
        if (axis.tlast) last_cnt++;
        if (exp_beat_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else chk("beat", 64'({axis.tlast, axis.tdata}), 64'(exp_beat_q.pop_front()));
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_beat  = {axis.tlast, axis.tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int len, output int acc);
    int n;
    @(posedge mem_clk);
    #1;
    cmd_gen++;
    for (int i = 0; i < len; i++) begin
      logic [ADDR_W-1:0] a;
      a = addr + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_beat_q.push_back({(i == len - 1), a});
    end
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = LEN_W'(len);
    n = 0;
    do begin
      @(negedge mem_clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) chk("cmd_accept_timeout", 64'd0, 64'd1);
    acc = cyc;
    @(posedge mem_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge mem_clk);
      n++;
    end while (!done && n < 1000);
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    @(negedge mem_clk);
    chk("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic checkOutput(input int len, input bit chk_lat, input int acc);
    chk("rd_count", 64'(rd_cnt), 64'(len));
    chk("beat_count", 64'(beat_cnt), 64'(len));
    chk("tlast_count", 64'(last_cnt), (len > 0) ? 64'd1 : 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("scoreboard_empty", 64'(exp_addr_q.size() + exp_beat_q.size()), 64'd0);
    chk("credit_bound", 64'(max_out <= MAXO), 64'd1);
    if (len == 0) begin
      chk("empty_done_cycle", 64'(done_cyc), 64'(acc + 1));
      chk("empty_no_tvalid", 64'(first_tv), 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      chk("done_after_last_beat", 64'(done_cyc), 64'(last_beat_cyc + 1));
    end
    if (chk_lat) begin
      chk("first_rd_latency", 64'(first_rd), 64'(acc + 1));
      chk("first_tvalid_latency", 64'(first_tv), 64'(acc + 2 + RDL));
      chk("full_rate", 64'(last_beat_cyc - first_tv), 64'(len - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int acc, seen, during;
    @(negedge mem_clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge mem_clk);
    #1;
    rst = 1'b0;
    @(negedge mem_clk);
    chk("reset_outputs",
        64'({cmd_ready, mem_rd_en, axis.tvalid, axis.tlast, busy, done}), 64'b100000);
    chk("reset_rd_addr", 64'(mem_rd_addr), 64'd0);

    // Basic burst at full rate, with latency checks
    applyStimulus(32'h100, 4, acc);
    waitDone();
    checkOutput(4, 1'b1, acc);

    // Backpressure pattern 1,0,0
    tready_mode = 1;
    applyStimulus(32'h200, 8, acc);
    waitDone();
    checkOutput(8, 1'b0, acc);
    tready_mode = 0;

    // prog_full raised after the third issue for 10 cycles
    applyStimulus(32'h300, 6, acc);
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      if (i > 0) @(negedge mem_clk);
      if (mem_rd_en) seen++;
    end
    chk("issued_before_full", 64'(seen), 64'd3);
    pf_force = 1'b1;
    during = 0;
    @(negedge mem_clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge mem_clk);
      if (mem_rd_en) during++;
    end
    pf_force = 1'b0;
    chk("rd_while_full", 64'(during), 64'd0);
    waitDone();
    checkOutput(6, 1'b0, acc);

    // Empty command
    applyStimulus(32'h400, 0, acc);
    waitDone();
    checkOutput(0, 1'b0, acc);

    // Address wrap
    applyStimulus(32'hFFFF_FFFE, 4, acc);
    waitDone();
    checkOutput(4, 1'b1, acc);

    // Reset with three reads in flight
    applyStimulus(32'h2000, 16, acc);
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      if (i > 0) @(negedge mem_clk);
      if (mem_rd_en) seen++;
    end
    rst = 1'b1;
    @(posedge mem_clk);
    #1;
    rst = 1'b0;
    exp_addr_q.delete();
    exp_beat_q.delete();
    @(negedge mem_clk);
    chk("abort_state", 64'({axis.tvalid, busy, cmd_ready, done}), 64'b0010);
    applyStimulus(32'h3000, 2, acc);
    waitDone();
    checkOutput(2, 1'b0, acc);

    // Randomized commands with random backpressure and prog_full
    tready_mode = 2;
    for (int k = 0; k < 10; k++) begin
      int len;
      logic [ADDR_W-1:0] a;
      pf_mode = $urandom_range(0, 1);
      len = $urandom_range(0, 20);
      a = $urandom();
      applyStimulus(a, len, acc);
      waitDone();
      checkOutput(len, 1'b0, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
